// File: rtl/riscv_pipe_ctrl_pkg.sv
// Shared types and control encodings for the pipeline hazard controller and the
// pipeline-register designators it drives.
package riscv_pipe_ctrl_pkg;
  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} hz_state_t;

  typedef struct packed {
    logic pc_write_en;
    logic if_id_write_en;
    logic if_id_flush;
    logic id_ex_write_en;
    logic id_ex_flush;
    logic ex_mem_write_en;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
endpackage

// File: rtl/hazard_wait_timer.sv
// Counts consecutive data-memory wait cycles, saturating at MEM_TIMEOUT, and
// raises a sticky error once the limit is reached.
module hazard_wait_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_stall,
  output logic o_timeout_err
);
  localparam logic [15:0] LIMIT = 16'(MEM_TIMEOUT);

  logic [15:0] r_cnt;
  logic        r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (i_stall) begin
      if (r_cnt != LIMIT) r_cnt <= r_cnt + 16'd1;
      // Set on the edge where the count lands on LIMIT; stays set until reset.
      if (r_cnt >= LIMIT - 16'd1) r_err <= 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_timeout_err = r_err;
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: load-use bubbles, redirect squash,
// memory-wait freeze. Define HAZARD_PERF_CNT_EN to build the performance counters.
module pipeline_hazard_controller
  import riscv_pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_write_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_write_en,
  output logic                  mem_timeout_err,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  hz_state_t  r_state, w_state_nxt;
  logic [2:0] r_fcnt, w_fcnt_nxt;
  logic       w_mem_stall, w_load_use;
  pipe_ctrl_t w_ctrl;

  assign w_mem_stall = mem_req & ~mem_ready;
  assign w_load_use  = ex_mem_read & (ex_rd != '0) &
                       ((id_uses_rs1 & (ex_rd == id_rs1)) |
                        (id_uses_rs2 & (ex_rd == id_rs2)));

  // MEM_WAIT without a stall falls through to the RUN behaviour.
  always_comb begin
    w_ctrl      = CTRL_RUN;
    w_state_nxt = RUN;
    w_fcnt_nxt  = r_fcnt;
    if (w_mem_stall) begin
      w_ctrl      = CTRL_FREEZE;
      w_state_nxt = MEM_WAIT;
    end else if (ex_redirect) begin
      w_ctrl.if_id_flush = 1'b1;
      w_ctrl.id_ex_flush = 1'b1;
      if (FLUSH_CYCLES > 0) begin
        w_state_nxt = FLUSH;
        w_fcnt_nxt  = FLUSH_LOAD;
      end
    end else if (r_state == FLUSH) begin
      w_ctrl.if_id_flush = 1'b1;
      w_ctrl.id_ex_flush = w_load_use;
      if (r_fcnt > 3'd1) begin
        w_state_nxt = FLUSH;
        w_fcnt_nxt  = r_fcnt - 3'd1;
      end
    end else if (w_load_use) begin
      w_ctrl.pc_write_en    = 1'b0;
      w_ctrl.if_id_write_en = 1'b0;
      w_ctrl.id_ex_flush    = 1'b1;
    end
    if (!RESET_N) w_ctrl = CTRL_RESET;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  hazard_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .i_clk         (CLK),
    .i_rst_n       (RESET_N),
    .i_stall       (w_mem_stall),
    .o_timeout_err (mem_timeout_err)
  );

  assign pc_write_en     = w_ctrl.pc_write_en;
  assign if_id_write_en  = w_ctrl.if_id_write_en;
  assign if_id_flush     = w_ctrl.if_id_flush;
  assign id_ex_write_en  = w_ctrl.id_ex_write_en;
  assign id_ex_flush     = w_ctrl.id_ex_flush;
  assign ex_mem_write_en = w_ctrl.ex_mem_write_en;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_flush_events;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!w_ctrl.pc_write_en)         r_stall_cycles <= r_stall_cycles + 32'd1;
      if (ex_redirect && !w_mem_stall) r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif
endmodule
